// File: rtl/tff_count_sequencer_if.sv
// Control/status bundle between a counter sequencer and whoever drives it.
// master drives the requests; slave (the sequencer) returns T, Q and status.
interface tff_count_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, up, load, load_val, limit,
    input  t, q, busy, done
  );

  modport slave (
    input  start, stop, up, load, load_val, limit,
    output t, q, busy, done
  );
endinterface

// File: rtl/tff_count_sequencer.sv
// Sequencer for a bank of T flip-flops acting as a loadable up/down counter.
// Each cycle the FSM picks the toggle-enable vector T; the bank applies Q ^= T.
module tff_count_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  tff_count_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] t_c;
  logic             carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      q_r   <= '0;
    end else begin
      state <= state_nxt;
      q_r   <= q_r ^ t_c;
    end
  end

  always_comb begin
    state_nxt = state;
    t_c       = '0;
    carry     = 1'b1;
    case (state)
      S_IDLE: begin
        if (bus.stop)       state_nxt = S_IDLE;
        else if (bus.load)  state_nxt = S_LOAD;
        else if (bus.start) state_nxt = S_RUN;
      end
      S_LOAD: begin
        t_c       = q_r ^ bus.load_val;
        state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (bus.stop) begin
          state_nxt = S_HOLD;
        end else if (q_r == bus.limit) begin
          state_nxt = S_DONE;
        end else begin
          // Bit i toggles when all lower bits are 1 (up) or all are 0 (down).
          for (int unsigned i = 0; i < WIDTH; i++) begin
            t_c[i] = carry;
            carry  = carry & (bus.up ? q_r[i] : ~q_r[i]);
          end
        end
      end
      S_HOLD: begin
        if (bus.stop)       state_nxt = S_IDLE;
        else if (bus.start) state_nxt = S_RUN;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.t    = t_c;
  assign bus.q    = q_r;
  assign bus.busy = (state == S_LOAD) || (state == S_RUN) || (state == S_HOLD);
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer: expected T/Q/Busy/Done per clock
// step are queued when inputs are driven and compared after the edge.
module tb_tff_count_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct {
    string      tag;
    logic [3:0] t;
    logic [3:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  tff_count_sequencer_if #(.WIDTH(4)) bus ();

  tff_count_sequencer #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: T is captured just before the edge (the toggles that edge applies),
  // Q/Busy/Done just after it.
  task automatic cyc(input string tag, input logic [3:0] et, input logic [3:0] eq,
                     input logic eb, input logic ed);
    exp_t e;
    logic [3:0] t_seen;
    e.tag = tag; e.t = et; e.q = eq; e.busy = eb; e.done = ed;
    sb.push_back(e);
    @(negedge clk);
    t_seen = bus.t;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s: got empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".t"},    {28'd0, t_seen},   {28'd0, e.t});
      chk({e.tag, ".q"},    {28'd0, bus.q},    {28'd0, e.q});
      chk({e.tag, ".busy"}, {31'd0, bus.busy}, {31'd0, e.busy});
      chk({e.tag, ".done"}, {31'd0, bus.done}, {31'd0, e.done});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.up = 1'b1; bus.load = 1'b0;
    bus.load_val = 4'd0; bus.limit = 4'd0;

    // Reset state
    #1;
    chk("rst.q",    {28'd0, bus.q},    32'd0);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk("rst.done", {31'd0, bus.done}, 32'd0);
    chk("rst.t",    {28'd0, bus.t},    32'd0);
    @(posedge clk); #1;
    chk("rst_hold.q", {28'd0, bus.q}, 32'd0);
    rst = 1'b0;

    // Count up 0 -> 5
    bus.up = 1'b1; bus.limit = 4'd5; bus.start = 1'b1;
    cyc("up_start", 4'b0000, 4'd0, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("up_1", 4'b0001, 4'd1, 1'b1, 1'b0);
    cyc("up_2", 4'b0011, 4'd2, 1'b1, 1'b0);
    cyc("up_3", 4'b0001, 4'd3, 1'b1, 1'b0);
    cyc("up_4", 4'b0111, 4'd4, 1'b1, 1'b0);
    cyc("up_5", 4'b0001, 4'd5, 1'b1, 1'b0);
    cyc("up_done", 4'b0000, 4'd5, 1'b0, 1'b1);
    cyc("up_idle", 4'b0000, 4'd5, 1'b0, 1'b0);
    cyc("up_idle2", 4'b0000, 4'd5, 1'b0, 1'b0);

    // Load 2, count down with wrap to 14
    bus.load_val = 4'd2; bus.load = 1'b1;
    cyc("ld2_req", 4'b0000, 4'd5, 1'b1, 1'b0);
    bus.load = 1'b0;
    cyc("ld2_apply", 4'b0111, 4'd2, 1'b0, 1'b0);
    bus.up = 1'b0; bus.limit = 4'd14; bus.start = 1'b1;
    cyc("dn_start", 4'b0000, 4'd2, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("dn_1",  4'b0011, 4'd1,  1'b1, 1'b0);
    cyc("dn_0",  4'b0001, 4'd0,  1'b1, 1'b0);
    cyc("dn_15", 4'b1111, 4'd15, 1'b1, 1'b0);
    cyc("dn_14", 4'b0001, 4'd14, 1'b1, 1'b0);
    cyc("dn_done", 4'b0000, 4'd14, 1'b0, 1'b1);
    cyc("dn_idle", 4'b0000, 4'd14, 1'b0, 1'b0);

    // Pause and resume toward 9
    bus.load_val = 4'd0; bus.load = 1'b1;
    cyc("ld0_req", 4'b0000, 4'd14, 1'b1, 1'b0);
    bus.load = 1'b0;
    cyc("ld0_apply", 4'b1110, 4'd0, 1'b0, 1'b0);
    bus.up = 1'b1; bus.limit = 4'd9; bus.start = 1'b1;
    cyc("pr_start", 4'b0000, 4'd0, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("pr_1", 4'b0001, 4'd1, 1'b1, 1'b0);
    cyc("pr_2", 4'b0011, 4'd2, 1'b1, 1'b0);
    cyc("pr_3", 4'b0001, 4'd3, 1'b1, 1'b0);
    bus.stop = 1'b1;
    cyc("pr_hold", 4'b0000, 4'd3, 1'b1, 1'b0);
    bus.stop = 1'b0;
    cyc("pr_hold2", 4'b0000, 4'd3, 1'b1, 1'b0);
    bus.start = 1'b1;
    cyc("pr_resume", 4'b0000, 4'd3, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("pr_4", 4'b0111, 4'd4, 1'b1, 1'b0);
    cyc("pr_5", 4'b0001, 4'd5, 1'b1, 1'b0);
    cyc("pr_6", 4'b0011, 4'd6, 1'b1, 1'b0);
    cyc("pr_7", 4'b0001, 4'd7, 1'b1, 1'b0);
    cyc("pr_8", 4'b1111, 4'd8, 1'b1, 1'b0);
    cyc("pr_9", 4'b0001, 4'd9, 1'b1, 1'b0);
    cyc("pr_done", 4'b0000, 4'd9, 1'b0, 1'b1);
    cyc("pr_idle", 4'b0000, 4'd9, 1'b0, 1'b0);

    // Abort: Stop+Start in RUN -> HOLD, again in HOLD -> IDLE, Stop wins in IDLE
    bus.limit = 4'd12; bus.start = 1'b1;
    cyc("ab_start", 4'b0000, 4'd9, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("ab_10", 4'b0011, 4'd10, 1'b1, 1'b0);
    bus.stop = 1'b1; bus.start = 1'b1;
    cyc("ab_hold", 4'b0000, 4'd10, 1'b1, 1'b0);
    cyc("ab_idle", 4'b0000, 4'd10, 1'b0, 1'b0);
    cyc("ab_stay", 4'b0000, 4'd10, 1'b0, 1'b0);
    bus.stop = 1'b0; bus.start = 1'b0;
    cyc("ab_quiet", 4'b0000, 4'd10, 1'b0, 1'b0);

    // Degenerate start with Q == Limit
    bus.load_val = 4'd7; bus.load = 1'b1;
    cyc("ld7_req", 4'b0000, 4'd10, 1'b1, 1'b0);
    bus.load = 1'b0;
    cyc("ld7_apply", 4'b1101, 4'd7, 1'b0, 1'b0);
    bus.limit = 4'd7; bus.start = 1'b1;
    cyc("eq_start", 4'b0000, 4'd7, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("eq_done", 4'b0000, 4'd7, 1'b0, 1'b1);
    cyc("eq_idle", 4'b0000, 4'd7, 1'b0, 1'b0);

    // Load during RUN/DONE is ignored
    bus.limit = 4'd9; bus.start = 1'b1;
    cyc("lr_start", 4'b0000, 4'd7, 1'b1, 1'b0);
    bus.start = 1'b0; bus.load = 1'b1; bus.load_val = 4'd0;
    cyc("lr_8", 4'b1111, 4'd8, 1'b1, 1'b0);
    cyc("lr_9", 4'b0001, 4'd9, 1'b1, 1'b0);
    cyc("lr_done", 4'b0000, 4'd9, 1'b0, 1'b1);
    bus.load = 1'b0;
    cyc("lr_idle", 4'b0000, 4'd9, 1'b0, 1'b0);

    // Async reset mid-RUN at Q=6
    bus.up = 1'b0; bus.limit = 4'd0; bus.start = 1'b1;
    cyc("ar_start", 4'b0000, 4'd9, 1'b1, 1'b0);
    bus.start = 1'b0;
    cyc("ar_8", 4'b0001, 4'd8, 1'b1, 1'b0);
    cyc("ar_7", 4'b1111, 4'd7, 1'b1, 1'b0);
    cyc("ar_6", 4'b0001, 4'd6, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_now.q",    {28'd0, bus.q},    32'd0);
    chk("ar_now.busy", {31'd0, bus.busy}, 32'd0);
    chk("ar_now.done", {31'd0, bus.done}, 32'd0);
    chk("ar_now.t",    {28'd0, bus.t},    32'd0);
    @(posedge clk); #1;
    chk("ar_held.q",    {28'd0, bus.q},    32'd0);
    chk("ar_held.done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    cyc("ar_idle", 4'b0000, 4'd0, 1'b0, 1'b0);

    // Priority: Load beats Start; Stop beats Load
    bus.load_val = 4'd3; bus.load = 1'b1; bus.start = 1'b1;
    cyc("pri_ld", 4'b0000, 4'd0, 1'b1, 1'b0);
    bus.load = 1'b0; bus.start = 1'b0;
    cyc("pri_apply", 4'b0011, 4'd3, 1'b0, 1'b0);
    bus.stop = 1'b1; bus.load = 1'b1; bus.load_val = 4'd12;
    cyc("pri_stop1", 4'b0000, 4'd3, 1'b0, 1'b0);
    cyc("pri_stop2", 4'b0000, 4'd3, 1'b0, 1'b0);
    bus.stop = 1'b0; bus.load = 1'b0;

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
